// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//
// Shared definitions for the bit-serial adder controller.
//   state_t    : FSM state encoding (IDLE / RUN / DONE)
//   WIDTH_DEF  : default operand width
//   CNT_W      : bit-counter width for the default operand width
//   cnt_width  : helper giving the bit-counter width for any operand width
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WIDTH_DEF = 8;

    // Counter must hold the values 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage : adder_pkg

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//
// Purely combinational 1-bit full adder.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit   (a ^ b ^ ci)
//   co   : carry out (majority of a, b, ci)
// -----------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ ci;
    assign co       = (a & b) | (ci & half_sum);

endmodule : fa_cell

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder: adds two WIDTH-bit operands plus a carry-in over WIDTH
// clock cycles, LSB first, using a single full-adder cell.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only while idle
//   a, b   : operands, captured on the accepting edge
//   cin    : carry-in, captured on the accepting edge
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, sum/cout valid
//   sum    : registered sum, held until the next result is written
//   cout   : registered carry-out, held with sum
//
// An operation accepted at edge 0 processes one bit on each of edges 1..WIDTH;
// the result registers are written on edge WIDTH, done is high for the cycle
// that follows, and the block is idle again one edge later.
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [WIDTH-1:0] a_sr_q,    a_sr_d;
    logic [WIDTH-1:0] b_sr_q,    b_sr_d;
    logic [WIDTH-1:0] sum_sr_q,  sum_sr_d;
    logic             carry_q,   carry_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic             cout_q,    cout_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    // -------------------------------------------------------------------------
    // Single shared full-adder cell, fed from the LSBs of the operand shifters
    // -------------------------------------------------------------------------
    logic fa_s;
    logic fa_co;

    fa_cell u_fa_cell (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Partial sum with the new bit entering at the MSB; after WIDTH shifts the
    // first (LSB) bit has reached position 0.
    logic [WIDTH-1:0] sum_shifted;
    assign sum_shifted = {fa_s, sum_sr_q[WIDTH-1:1]};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        carry_d   = carry_q;
        bit_cnt_d = bit_cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d    = a;
                    b_sr_d    = b;
                    carry_d   = cin;
                    bit_cnt_d = '0;
                    state_d   = RUN;
                end
            end

            RUN: begin
                sum_sr_d  = sum_shifted;
                a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d   = fa_co;
                bit_cnt_d = bit_cnt_q + CW'(1);
                // Last bit: publish the result. start is not looked at here,
                // so a request arriving on this edge is simply dropped.
                if (bit_cnt_q == LAST_CNT) begin
                    sum_d   = sum_shifted;
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered and follow the state being entered,
        // so they line up exactly with the state register.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            carry_q   <= 1'b0;
            bit_cnt_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            sum_sr_q  <= sum_sr_d;
            carry_q   <= carry_d;
            bit_cnt_q <= bit_cnt_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder_ctrl
